// File: rtl/spi_nios_link_master.sv
// SPI mode-0 master feeding the Nios-side SPI slave of soc_system.
// One DATA_W word per valid/ready handshake, MSB first; received word returned with a one-cycle rx_valid.
module spi_nios_link_master #(
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned CLK_DIV  = 4,
    parameter int unsigned CS_SETUP = 2,
    parameter int unsigned CS_HOLD  = 2,
    parameter int unsigned GAP      = 4
) (
    input  logic              clk_clk,
    input  logic              reset_reset_n,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              busy,
    output logic              spi_sclk,
    output logic              spi_mosi,
    output logic              spi_ss_n,
    input  logic              spi_miso
);

    localparam int unsigned SEQ_MAX_A = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
    localparam int unsigned SEQ_MAX   = (SEQ_MAX_A > GAP) ? SEQ_MAX_A : GAP;
    localparam int unsigned SEQ_W     = $clog2(SEQ_MAX + 1);
    localparam int unsigned HALF_W    = $clog2(CLK_DIV);
    localparam int unsigned BIT_W     = $clog2(DATA_W);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_SHIFT,
        S_HOLD,
        S_GAP
    } state_t;

    state_t              state_q, state_d;
    logic [SEQ_W-1:0]    seq_q, seq_d;
    logic [HALF_W-1:0]   half_q, half_d;
    logic [BIT_W-1:0]    bit_q, bit_d;
    logic [DATA_W-1:0]   tx_shift_q, tx_shift_d;
    logic [DATA_W-1:0]   rx_shift_q, rx_shift_d;
    logic                tx_ready_d;
    logic [DATA_W-1:0]   rx_data_d;
    logic                rx_valid_d;
    logic                busy_d;
    logic                sclk_d;
    logic                mosi_d;
    logic                ss_n_d;

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state_q    <= S_IDLE;
            seq_q      <= '0;
            half_q     <= '0;
            bit_q      <= '0;
            tx_shift_q <= '0;
            rx_shift_q <= '0;
            tx_ready   <= 1'b0;
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            busy       <= 1'b0;
            spi_sclk   <= 1'b0;
            spi_mosi   <= 1'b0;
            spi_ss_n   <= 1'b1;
        end else begin
            state_q    <= state_d;
            seq_q      <= seq_d;
            half_q     <= half_d;
            bit_q      <= bit_d;
            tx_shift_q <= tx_shift_d;
            rx_shift_q <= rx_shift_d;
            tx_ready   <= tx_ready_d;
            rx_data    <= rx_data_d;
            rx_valid   <= rx_valid_d;
            busy       <= busy_d;
            spi_sclk   <= sclk_d;
            spi_mosi   <= mosi_d;
            spi_ss_n   <= ss_n_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        seq_d      = seq_q;
        half_d     = half_q;
        bit_d      = bit_q;
        tx_shift_d = tx_shift_q;
        rx_shift_d = rx_shift_q;
        tx_ready_d = tx_ready;
        rx_data_d  = rx_data;
        rx_valid_d = 1'b0;
        busy_d     = busy;
        sclk_d     = spi_sclk;
        mosi_d     = spi_mosi;
        ss_n_d     = spi_ss_n;

        case (state_q)
            S_IDLE: begin
                // tx_ready is a register, so it comes up one edge after reset release
                tx_ready_d = 1'b1;
                if (tx_valid && tx_ready) begin
                    tx_shift_d = tx_data;
                    mosi_d     = tx_data[DATA_W-1];
                    ss_n_d     = 1'b0;
                    busy_d     = 1'b1;
                    tx_ready_d = 1'b0;
                    seq_d      = '0;
                    state_d    = S_SETUP;
                end
            end

            S_SETUP: begin
                if (seq_q == SEQ_W'(CS_SETUP - 1)) begin
                    seq_d   = '0;
                    half_d  = '0;
                    bit_d   = '0;
                    state_d = S_SHIFT;
                end else begin
                    seq_d = seq_q + 1'b1;
                end
            end

            S_SHIFT: begin
                if (half_q == HALF_W'(CLK_DIV - 1)) begin
                    half_d = '0;
                    if (!spi_sclk) begin
                        sclk_d     = 1'b1;
                        rx_shift_d = {rx_shift_q[DATA_W-2:0], spi_miso};
                    end else begin
                        sclk_d = 1'b0;
                        if (bit_q == BIT_W'(DATA_W - 1)) begin
                            seq_d   = '0;
                            state_d = S_HOLD;
                        end else begin
                            bit_d      = bit_q + 1'b1;
                            tx_shift_d = {tx_shift_q[DATA_W-2:0], 1'b0};
                            mosi_d     = tx_shift_q[DATA_W-2];
                        end
                    end
                end else begin
                    half_d = half_q + 1'b1;
                end
            end

            S_HOLD: begin
                if (seq_q == SEQ_W'(CS_HOLD - 1)) begin
                    ss_n_d     = 1'b1;
                    mosi_d     = 1'b0;
                    rx_data_d  = rx_shift_q;
                    rx_valid_d = 1'b1;
                    seq_d      = '0;
                    state_d    = S_GAP;
                end else begin
                    seq_d = seq_q + 1'b1;
                end
            end

            S_GAP: begin
                if (seq_q == SEQ_W'(GAP - 1)) begin
                    busy_d     = 1'b0;
                    tx_ready_d = 1'b1;
                    seq_d      = '0;
                    state_d    = S_IDLE;
                end else begin
                    seq_d = seq_q + 1'b1;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_spi_nios_link_master.sv
// Directed bench for spi_nios_link_master: scoreboard on rx words plus an SPI protocol monitor.
// Instance a uses default parameters, instance b uses DATA_W=8, CLK_DIV=6 with MISO tied high.
module tb_spi_nios_link_master;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    function automatic void check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endfunction

    // instance a
    logic        rst_n = 1'b0;
    logic [15:0] tx_data = '0;
    logic        tx_valid = 1'b0;
    logic        tx_ready;
    logic [15:0] rx_data;
    logic        rx_valid;
    logic        busy;
    logic        sclk;
    logic        mosi;
    logic        ss_n;
    logic        miso = 1'b0;

    spi_nios_link_master #(
        .DATA_W(16), .CLK_DIV(4), .CS_SETUP(2), .CS_HOLD(2), .GAP(4)
    ) dut_a (
        .clk_clk(clk), .reset_reset_n(rst_n),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy),
        .spi_sclk(sclk), .spi_mosi(mosi), .spi_ss_n(ss_n), .spi_miso(miso)
    );

    // instance b
    logic        rst_b = 1'b0;
    logic [7:0]  tx_data_b = '0;
    logic        tx_valid_b = 1'b0;
    logic        tx_ready_b;
    logic [7:0]  rx_data_b;
    logic        rx_valid_b;
    logic        busy_b;
    logic        sclk_b;
    logic        mosi_b;
    logic        ss_n_b;
    logic        miso_b = 1'b1;

    spi_nios_link_master #(
        .DATA_W(8), .CLK_DIV(6), .CS_SETUP(2), .CS_HOLD(2), .GAP(4)
    ) dut_b (
        .clk_clk(clk), .reset_reset_n(rst_b),
        .tx_data(tx_data_b), .tx_valid(tx_valid_b), .tx_ready(tx_ready_b),
        .rx_data(rx_data_b), .rx_valid(rx_valid_b), .busy(busy_b),
        .spi_sclk(sclk_b), .spi_mosi(mosi_b), .spi_ss_n(ss_n_b), .spi_miso(miso_b)
    );

    // scoreboard queues
    logic [15:0] tx_q[$];
    logic [15:0] slave_q[$];
    logic [15:0] exp_rx_q[$];
    logic [7:0]  exp_rx_b[$];

    // monitor / slave model state for instance a
    bit          abort = 1'b0;
    int          rises = 0;
    int          rxv_count = 0;
    int          xfers = 0;

    initial begin : mon_a
        logic        prev_ss, prev_sclk, prev_mosi, prev_rxv, after_rise;
        logic [15:0] cur_tx, cur_slave;
        int          low_len, high_len, idx;
        prev_ss = 1'b1; prev_sclk = 1'b0; prev_mosi = 1'b0; prev_rxv = 1'b0; after_rise = 1'b0;
        cur_tx = '0; cur_slave = '0; low_len = 0; high_len = 1000; idx = 15;
        forever begin
            @(negedge clk);
            if (prev_ss && !ss_n) begin
                if (!abort) check("ss_high_gap", high_len >= 4, 1'b1);
                xfers++;
                low_len = 0;
                rises = 0;
                idx = 15;
                cur_tx = (tx_q.size() > 0) ? tx_q.pop_front() : 16'h0;
                cur_slave = (slave_q.size() > 0) ? slave_q.pop_front() : 16'h0;
            end
            if (!ss_n) low_len++;
            high_len = ss_n ? high_len + 1 : 0;
            if (prev_ss != ss_n && !abort) check("sclk_low_at_ss_edge", {prev_sclk, sclk}, 2'b00);
            if (!prev_sclk && sclk) begin
                if (!abort) begin
                    check("ss_low_at_rise", ss_n, 1'b0);
                    check("mosi_setup", mosi, prev_mosi);
                    if (rises < 16) check("mosi_bit", mosi, cur_tx[15 - rises]);
                end
                rises++;
                after_rise = 1'b1;
            end else if (after_rise) begin
                if (!abort) check("mosi_hold", mosi, prev_mosi);
                after_rise = 1'b0;
            end
            if (prev_sclk && !sclk && idx > 0) idx--;
            if (!prev_ss && ss_n && !abort) begin
                check("sclk_pulses", rises, 16);
                check("ss_low_len", low_len, 132);
            end
            if (rx_valid) begin
                rxv_count++;
                check("rx_valid_width", prev_rxv, 1'b0);
                if (exp_rx_q.size() > 0) check("rx_data", rx_data, exp_rx_q.pop_front());
                else check("rx_unexpected", rx_valid, 1'b0);
            end
            // mode-0 slave: MSB presented while SS_n low, next bit after each SCLK fall
            miso = ss_n ? 1'b0 : cur_slave[idx];
            prev_ss = ss_n; prev_sclk = sclk; prev_mosi = mosi; prev_rxv = rx_valid;
        end
    end

    int rxv_count_b = 0;

    initial begin : mon_b
        logic       prev_ss, prev_sclk;
        logic [7:0] word_b;
        int         ncyc, last_rise, rises_b, low_b;
        prev_ss = 1'b1; prev_sclk = 1'b0; word_b = 8'h81;
        ncyc = 0; last_rise = 0; rises_b = 0; low_b = 0;
        forever begin
            @(negedge clk);
            ncyc++;
            if (prev_ss && !ss_n_b) begin
                rises_b = 0;
                low_b = 0;
            end
            if (!ss_n_b) low_b++;
            if (prev_ss != ss_n_b) check("b_sclk_low_at_ss_edge", {prev_sclk, sclk_b}, 2'b00);
            if (!prev_sclk && sclk_b) begin
                check("b_ss_low_at_rise", ss_n_b, 1'b0);
                if (rises_b > 0) check("b_sclk_period", ncyc - last_rise, 12);
                if (rises_b < 8) check("b_mosi_bit", mosi_b, word_b[7 - rises_b]);
                last_rise = ncyc;
                rises_b++;
            end
            if (!prev_ss && ss_n_b) begin
                check("b_sclk_pulses", rises_b, 8);
                check("b_ss_low_len", low_b, 100);
            end
            if (rx_valid_b) begin
                rxv_count_b++;
                if (exp_rx_b.size() > 0) check("b_rx_data", rx_data_b, exp_rx_b.pop_front());
                else check("b_rx_unexpected", rx_valid_b, 1'b0);
            end
            prev_ss = ss_n_b; prev_sclk = sclk_b;
        end
    end

    // called at a negedge; returns one negedge after the accepting posedge
    task automatic send_a(input logic [15:0] w, input logic [15:0] s);
        int waited;
        tx_q.push_back(w);
        slave_q.push_back(s);
        exp_rx_q.push_back(s);
        tx_data = w;
        tx_valid = 1'b1;
        waited = 0;
        while (!tx_ready && waited < 1000) begin
            @(negedge clk);
            waited++;
        end
        if (!tx_ready) check("accept_timeout", tx_ready, 1'b1);
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    task automatic wait_ready_a(input string tag);
        int waited;
        waited = 0;
        while (!tx_ready && waited < 1000) begin
            @(negedge clk);
            waited++;
        end
        if (!tx_ready) check(tag, tx_ready, 1'b1);
    endtask

    initial begin : stim
        int n0, gap, x0, w;

        repeat (3) @(negedge clk);
        check("rst_ss_n", ss_n, 1'b1);
        check("rst_sclk", sclk, 1'b0);
        check("rst_mosi", mosi, 1'b0);
        check("rst_tx_ready", tx_ready, 1'b0);
        check("rst_rx_valid", rx_valid, 1'b0);
        check("rst_rx_data", rx_data, 16'h0);
        check("rst_busy", busy, 1'b0);
        rst_n = 1'b1;
        rst_b = 1'b1;
        @(negedge clk);
        check("ready_after_reset", tx_ready, 1'b1);
        check("busy_after_reset", busy, 1'b0);

        // single transfer
        n0 = rxv_count;
        send_a(16'hA5C3, 16'h3C5A);
        check("t1_busy", busy, 1'b1);
        check("t1_tx_ready_low", tx_ready, 1'b0);
        wait_ready_a("t1_done_timeout");
        @(negedge clk);
        check("t1_rx_once", rxv_count - n0, 1);
        check("t1_rx_hold", rx_data, 16'h3C5A);
        check("t1_busy_done", busy, 1'b0);

        // back-to-back with tx_valid held
        tx_q.push_back(16'h0000); slave_q.push_back(16'hFFFF); exp_rx_q.push_back(16'hFFFF);
        tx_q.push_back(16'hFFFF); slave_q.push_back(16'h0000); exp_rx_q.push_back(16'h0000);
        tx_data = 16'h0000;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_data = 16'hFFFF;
        gap = 0;
        while (!tx_ready && gap < 1000) begin
            @(negedge clk);
            gap++;
        end
        check("t2_accept_spacing", gap + 1, 137);
        @(negedge clk);
        tx_valid = 1'b0;
        wait_ready_a("t2_done_timeout");
        @(negedge clk);
        check("t2_queue_drained", exp_rx_q.size(), 0);

        // tx_valid toggling while busy is ignored
        send_a(16'h5A5A, 16'h1111);
        for (int i = 0; i < 135; i++) begin
            tx_data = 16'hDEAD;
            tx_valid = ~tx_valid;
            check("t4_ready_low", tx_ready, 1'b0);
            @(negedge clk);
        end
        tx_valid = 1'b0;
        check("t4_ready_low_last", tx_ready, 1'b0);
        x0 = xfers;
        @(negedge clk);
        check("t4_ready_after_gap", tx_ready, 1'b1);
        repeat (200) @(negedge clk);
        check("t4_no_extra_xfer", xfers, x0);
        check("t4_queue_drained", exp_rx_q.size(), 0);

        // reset after the 7th SCLK rise
        send_a(16'h9876, 16'h4321);
        repeat (2) @(negedge clk);
        w = 0;
        while (rises < 7 && w < 1000) begin
            @(negedge clk);
            w++;
        end
        check("t3_reach_rise7", rises >= 7, 1'b1);
        n0 = rxv_count;
        #2;
        abort = 1'b1;
        rst_n = 1'b0;
        #1;
        check("t3_ss_n", ss_n, 1'b1);
        check("t3_sclk", sclk, 1'b0);
        check("t3_mosi", mosi, 1'b0);
        check("t3_busy", busy, 1'b0);
        check("t3_tx_ready", tx_ready, 1'b0);
        exp_rx_q.delete();
        tx_q.delete();
        slave_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        abort = 1'b0;
        check("t3_no_rx_valid", rxv_count, n0);
        send_a(16'h1234, 16'hBEEF);
        wait_ready_a("t3_done_timeout");
        @(negedge clk);
        check("t3_rx_after_reset", rxv_count - n0, 1);
        check("t3_queue_drained", exp_rx_q.size(), 0);

        // instance b: 8-bit word, MISO tied high
        exp_rx_b.push_back(8'hFF);
        tx_data_b = 8'h81;
        tx_valid_b = 1'b1;
        w = 0;
        while (!tx_ready_b && w < 1000) begin
            @(negedge clk);
            w++;
        end
        @(negedge clk);
        tx_valid_b = 1'b0;
        check("b_busy", busy_b, 1'b1);
        w = 0;
        while (!tx_ready_b && w < 1000) begin
            @(negedge clk);
            w++;
        end
        check("b_done", tx_ready_b, 1'b1);
        @(negedge clk);
        check("b_rx_once", rxv_count_b, 1);
        check("b_rx_hold", rx_data_b, 8'hFF);
        check("b_queue_drained", exp_rx_b.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
